// File: rtl/fmul_res_pack.sv
// FMUL32 final stage: normalise, round, range-check and pack a binary32 result
// through a two-deep valid/ready pipeline. Optional macro FMUL_ROUND_MODES_EN adds directed rounding.
module fmul_res_pack #(
  parameter int EXP_W  = 10,
  parameter int MANT_W = 23
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2*(MANT_W+1)-1:0]     mant_prod,
  input  logic signed [EXP_W-1:0]     exp_sum,
  input  logic                        res_sign,
  input  logic [1:0]                  res_NANs,
  input  logic                        res_INF,
  input  logic                        res_ZERO,
`ifdef FMUL_ROUND_MODES_EN
  input  logic [1:0]                  rnd_mode,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [MANT_W+8:0]           result,
  output logic                        exc_invalid,
  output logic                        exc_overflow,
  output logic                        exc_underflow,
  output logic                        exc_inexact
);

  localparam int PW = 2*(MANT_W+1);
  localparam int EW = EXP_W+1;
  localparam logic signed [EW-1:0] E_ONE  = {{(EW-1){1'b0}}, 1'b1};
  localparam logic signed [EW-1:0] E_SAT  = {{(EW-8){1'b0}}, 8'hFF};
  localparam logic signed [EW-1:0] E_ZERO = {EW{1'b0}};
  localparam logic [MANT_W+8:0]    QNAN   = {1'b0, 8'hFF, 1'b1, {(MANT_W-1){1'b0}}};

  logic                    s1_v_r, s2_v_r;
  logic                    s2_acc_s;
  logic [MANT_W-1:0]       norm_frac_s, s1_frac_r;
  logic                    norm_g_s, norm_st_s, s1_g_r, s1_st_r;
  logic signed [EW-1:0]    norm_e_s, s1_e_r;
  logic                    s1_sign_r, s1_inf_r, s1_zero_r;
  logic [1:0]              s1_nan_r;
`ifdef FMUL_ROUND_MODES_EN
  logic [1:0]              s1_rnd_r;
  logic                    ovf_max_s;
`endif
  logic                    inc_s;
  logic [MANT_W:0]         rnd_sum_s;
  logic signed [EW-1:0]    rnd_e_s;
  logic [MANT_W+8:0]       pack_s, result_r;
  logic [3:0]              flags_s, flags_r;

  assign s2_acc_s = ~s2_v_r | out_ready;
  assign in_ready = ~s1_v_r | s2_acc_s;

  // Normalise the product so the hidden bit lands at the top; a set MSB bumps the exponent.
  always_comb begin
    norm_frac_s = {MANT_W{1'b0}};
    norm_g_s    = 1'b0;
    norm_st_s   = 1'b0;
    norm_e_s    = {exp_sum[EXP_W-1], exp_sum};
    if (mant_prod[PW-1]) begin
      norm_frac_s = mant_prod[PW-2 -: MANT_W];
      norm_g_s    = mant_prod[PW-2-MANT_W];
      norm_st_s   = |mant_prod[PW-3-MANT_W:0];
      norm_e_s    = {exp_sum[EXP_W-1], exp_sum} + E_ONE;
    end else begin
      norm_frac_s = mant_prod[PW-3 -: MANT_W];
      norm_g_s    = mant_prod[PW-3-MANT_W];
      norm_st_s   = |mant_prod[PW-4-MANT_W:0];
    end
  end

  // Stage 1 register: normalised operand plus its special-case class.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_r    <= 1'b0;
      s1_frac_r <= {MANT_W{1'b0}};
      s1_g_r    <= 1'b0;
      s1_st_r   <= 1'b0;
      s1_e_r    <= E_ZERO;
      s1_sign_r <= 1'b0;
      s1_nan_r  <= 2'b00;
      s1_inf_r  <= 1'b0;
      s1_zero_r <= 1'b0;
`ifdef FMUL_ROUND_MODES_EN
      s1_rnd_r  <= 2'b00;
`endif
    end else if (in_ready) begin
      s1_v_r <= in_valid;
      if (in_valid) begin
        s1_frac_r <= norm_frac_s;
        s1_g_r    <= norm_g_s;
        s1_st_r   <= norm_st_s;
        s1_e_r    <= norm_e_s;
        s1_sign_r <= res_sign;
        s1_nan_r  <= res_NANs;
        s1_inf_r  <= res_INF;
        s1_zero_r <= res_ZERO;
`ifdef FMUL_ROUND_MODES_EN
        s1_rnd_r  <= rnd_mode;
`endif
      end
    end
  end

  // Rounding increment for the selected mode.
  always_comb begin
    inc_s = 1'b0;
`ifdef FMUL_ROUND_MODES_EN
    ovf_max_s = 1'b0;
    case (s1_rnd_r)
      2'b00: begin
        inc_s = s1_g_r & (s1_st_r | s1_frac_r[0]);
      end
      2'b01: begin
        inc_s     = 1'b0;
        ovf_max_s = 1'b1;
      end
      2'b10: begin
        inc_s     = ~s1_sign_r & (s1_g_r | s1_st_r);
        ovf_max_s = s1_sign_r;
      end
      2'b11: begin
        inc_s     = s1_sign_r & (s1_g_r | s1_st_r);
        ovf_max_s = ~s1_sign_r;
      end
      default: begin
        inc_s     = 1'b0;
        ovf_max_s = 1'b0;
      end
    endcase
`else
    inc_s = s1_g_r & (s1_st_r | s1_frac_r[0]);
`endif
  end

  assign rnd_sum_s = {1'b0, s1_frac_r} + {{MANT_W{1'b0}}, inc_s};
  assign rnd_e_s   = s1_e_r + {{(EW-1){1'b0}}, rnd_sum_s[MANT_W]};

  // Result select; range checks use the exponent after the rounding carry.
  // flags_s = {invalid, overflow, underflow, inexact}
  always_comb begin
    pack_s  = {(MANT_W+9){1'b0}};
    flags_s = 4'b0000;
    if (s1_nan_r != 2'b00) begin
      pack_s  = QNAN;
      flags_s = {s1_nan_r[1], 3'b000};
    end else if (s1_inf_r) begin
      pack_s  = {s1_sign_r, 8'hFF, {MANT_W{1'b0}}};
    end else if (s1_zero_r) begin
      pack_s  = {s1_sign_r, 8'h00, {MANT_W{1'b0}}};
    end else if (rnd_e_s >= E_SAT) begin
      flags_s = 4'b0101;
`ifdef FMUL_ROUND_MODES_EN
      if (ovf_max_s) begin
        pack_s = {s1_sign_r, 8'hFE, {MANT_W{1'b1}}};
      end else begin
        pack_s = {s1_sign_r, 8'hFF, {MANT_W{1'b0}}};
      end
`else
      pack_s  = {s1_sign_r, 8'hFF, {MANT_W{1'b0}}};
`endif
    end else if (rnd_e_s <= E_ZERO) begin
      pack_s  = {s1_sign_r, 8'h00, {MANT_W{1'b0}}};
      flags_s = 4'b0011;
    end else begin
      pack_s  = {s1_sign_r, rnd_e_s[7:0], rnd_sum_s[MANT_W-1:0]};
      flags_s = {3'b000, s1_g_r | s1_st_r};
    end
  end

  // Stage 2 register: packed result and flags held until the consumer takes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_r   <= 1'b0;
      result_r <= {(MANT_W+9){1'b0}};
      flags_r  <= 4'b0000;
    end else if (s2_acc_s) begin
      s2_v_r <= s1_v_r;
      if (s1_v_r) begin
        result_r <= pack_s;
        flags_r  <= flags_s;
      end
    end
  end

  assign out_valid     = s2_v_r;
  assign result        = result_r;
  assign exc_invalid   = flags_r[3];
  assign exc_overflow  = flags_r[2];
  assign exc_underflow = flags_r[1];
  assign exc_inexact   = flags_r[0];

endmodule

// File: tb/tb_fmul_res_pack.sv
// Scoreboard bench for fmul_res_pack: directed vectors with hand-computed results.
module tb_fmul_res_pack;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid, in_ready;
  logic [47:0]        mant_prod;
  logic signed [9:0]  exp_sum;
  logic               res_sign, res_INF, res_ZERO;
  logic [1:0]         res_NANs;
  logic               out_valid, out_ready;
  logic [31:0]        result;
  logic               exc_invalid, exc_overflow, exc_underflow, exc_inexact;

  int errors = 0;
  int checks = 0;
  logic [35:0] sb_q[$];
  logic        hold_prev;
  logic [35:0] hold_val;

  always #5 clk = ~clk;

  fmul_res_pack dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mant_prod(mant_prod), .exp_sum(exp_sum), .res_sign(res_sign),
    .res_NANs(res_NANs), .res_INF(res_INF), .res_ZERO(res_ZERO),
`ifdef FMUL_ROUND_MODES_EN
    .rnd_mode(2'b00),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .exc_invalid(exc_invalid), .exc_overflow(exc_overflow),
    .exc_underflow(exc_underflow), .exc_inexact(exc_inexact)
  );

  task automatic chk(input string name, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks stability under stall.
  initial begin
    hold_prev = 1'b0;
    hold_val  = 36'h0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          chk("hold_valid", {35'h0, out_valid}, 36'h1);
          chk("hold_data", {result, exc_invalid, exc_overflow, exc_underflow, exc_inexact}, hold_val);
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %h expected none", result);
          end else begin
            chk("result_flags", {result, exc_invalid, exc_overflow, exc_underflow, exc_inexact},
                sb_q.pop_front());
          end
        end
        hold_prev = out_valid && !out_ready;
        hold_val  = {result, exc_invalid, exc_overflow, exc_underflow, exc_inexact};
      end
    end
  end

  task automatic drive(input logic [47:0] mp, input logic signed [9:0] es, input logic sg,
                       input logic [1:0] nans, input logic inf, input logic zero);
    in_valid  = 1'b1;
    mant_prod = mp;
    exp_sum   = es;
    res_sign  = sg;
    res_NANs  = nans;
    res_INF   = inf;
    res_ZERO  = zero;
  endtask

  task automatic send(input logic [47:0] mp, input logic signed [9:0] es, input logic sg,
                      input logic [1:0] nans, input logic inf, input logic zero,
                      input logic [31:0] exp_res, input logic [3:0] exp_flags);
    int w;
    @(negedge clk);
    drive(mp, es, sg, nans, inf, zero);
    #1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
      in_valid = 1'b0;
    end else begin
      sb_q.push_back({exp_res, exp_flags});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; mant_prod = 48'h0; exp_sum = 10'sd0;
    res_sign = 1'b0; res_NANs = 2'b00; res_INF = 1'b0; res_ZERO = 1'b0;
    #3;
    chk("rst_out_valid", {35'h0, out_valid}, 36'h0);
    chk("rst_result", {4'h0, result}, 36'h0);
    chk("rst_flags", {32'h0, exc_invalid, exc_overflow, exc_underflow, exc_inexact}, 36'h0);
    #20 rst_n = 1'b1;
    @(negedge clk);
    #1 chk("rst_in_ready", {35'h0, in_ready}, 36'h1);

    // Numeric path
    send(48'h900000000000, 10'sd127, 1'b0, 2'b00, 1'b0, 1'b0, 32'h40100000, 4'b0000);
    send(48'h400000400000, 10'sd127, 1'b0, 2'b00, 1'b0, 1'b0, 32'h3F800000, 4'b0001);
    send(48'h400000C00000, 10'sd127, 1'b0, 2'b00, 1'b0, 1'b0, 32'h3F800002, 4'b0001);
    send(48'h400000800000, 10'sd127, 1'b0, 2'b00, 1'b0, 1'b0, 32'h3F800001, 4'b0000);
    send(48'h400000000001, 10'sd127, 1'b0, 2'b00, 1'b0, 1'b0, 32'h3F800000, 4'b0001);
    send(48'h800000000000, 10'sd254, 1'b1, 2'b00, 1'b0, 1'b0, 32'hFF800000, 4'b0101);
    send(48'h7FFFFFC00000, 10'sd254, 1'b0, 2'b00, 1'b0, 1'b0, 32'h7F800000, 4'b0101);
    send(48'h7FFFFF800000, 10'sd254, 1'b0, 2'b00, 1'b0, 1'b0, 32'h7F7FFFFF, 4'b0000);
    send(48'h400000000000, 10'sd0,   1'b0, 2'b00, 1'b0, 1'b0, 32'h00000000, 4'b0011);
    send(48'h400000000000, -10'sd5,  1'b1, 2'b00, 1'b0, 1'b0, 32'h80000000, 4'b0011);
    send(48'h800000000000, 10'sd0,   1'b0, 2'b00, 1'b0, 1'b0, 32'h00800000, 4'b0000);
    // Special cases ignore mant_prod
    send(48'h123456789ABC, 10'sd99,  1'b1, 2'b10, 1'b0, 1'b0, 32'h7FC00000, 4'b1000);
    send(48'h123456789ABC, 10'sd99,  1'b1, 2'b01, 1'b1, 1'b0, 32'h7FC00000, 4'b0000);
    send(48'hFFFFFFFFFFFF, 10'sd300, 1'b1, 2'b00, 1'b1, 1'b0, 32'hFF800000, 4'b0000);
    send(48'h900000000000, 10'sd127, 1'b0, 2'b00, 1'b0, 1'b1, 32'h00000000, 4'b0000);
    send(48'h900000000000, 10'sd127, 1'b1, 2'b00, 1'b0, 1'b1, 32'h80000000, 4'b0000);
    drain();

    // Backpressure: two accepts fill the pipe, then in_ready must drop
    out_ready = 1'b0;
    send(48'h900000000000, 10'sd126, 1'b0, 2'b00, 1'b0, 1'b0, 32'h3F900000, 4'b0000);
    send(48'h900000000000, 10'sd128, 1'b0, 2'b00, 1'b0, 1'b0, 32'h40900000, 4'b0000);
    @(negedge clk);
    drive(48'h800000000000, 10'sd127, 1'b0, 2'b00, 1'b0, 1'b0);
    #1 chk("in_ready_drop", {35'h0, in_ready}, 36'h0);
    @(negedge clk);
    #1 chk("in_ready_stall", {35'h0, in_ready}, 36'h0);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    send(48'h800000000000, 10'sd127, 1'b0, 2'b00, 1'b0, 1'b0, 32'h40000000, 4'b0000);
    send(48'h400000000000, 10'sd127, 1'b0, 2'b00, 1'b0, 1'b0, 32'h3F800000, 4'b0000);
    drain();

    // Reset with both stages full discards them
    out_ready = 1'b0;
    send(48'h400000000000, 10'sd127, 1'b0, 2'b00, 1'b0, 1'b0, 32'h3F800000, 4'b0000);
    send(48'h900000000000, 10'sd127, 1'b0, 2'b00, 1'b0, 1'b0, 32'h40100000, 4'b0000);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {35'h0, out_valid}, 36'h0);
    chk("async_rst_result", {4'h0, result}, 36'h0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    #2 rst_n = 1'b1;
    send(48'h900000000000, 10'sd127, 1'b0, 2'b00, 1'b0, 1'b0, 32'h40100000, 4'b0000);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!out_valid && n < 10);
    chk("latency", 36'(n), 36'd2);
    drain();
    chk("sb_empty", 36'(sb_q.size()), 36'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
